// File: rtl/fp_pkg.sv
// Shared definitions for the fp_norm_pack slice.
// Holds the normalizer state encoding, the IEEE-754 binary32 field
// constants and the codes carried on the in_special input.
// No ports; imported with "import fp_pkg::*".
package fp_pkg;

  // Normalizer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // binary32 field constants.
  localparam logic [7:0]  EXP_INF  = 8'hFF;
  localparam logic [22:0] QNAN_MAN = 23'h400000;
  localparam int          BIAS     = 127;

  // Special-operand codes from the adder stage.
  localparam logic [1:0] SPC_NORMAL = 2'b00;
  localparam logic [1:0] SPC_INF    = 2'b01;
  localparam logic [1:0] SPC_NAN    = 2'b10;
  localparam logic [1:0] SPC_RSVD   = 2'b11;

endpackage

// File: rtl/fp_norm_pack_if.sv
// Handshake bundle between the mantissa adder, the normalizer and the
// result consumer.
//   in_*  : operand channel (valid/ready), sign, exponent, 27-bit raw sum,
//           special code
//   out_* : result channel (valid/ready), packed binary32 word and
//           overflow/underflow flags
// Modports: master = the producer/consumer side, slave = the normalizer.
interface fp_norm_pack_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_sum;
  logic [1:0]  in_special;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_sum, in_special, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sum, in_special, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );

endinterface

// File: rtl/fp_round_pack.sv
// Combinational packer: turns a normalized (or given-up) signed-magnitude
// sum into a binary32 word.
//   sign, exp[8:0]  : result sign and 9-bit working exponent
//   sum[26:0]       : [25] hidden, [24:2] mantissa, [1] guard, [0] sticky
//   special[1:0]    : 00 normal, 01 inf, 10/11 NaN
//   denorm          : pack with exponent field 0 instead of exp
//   result[31:0]    : packed word; overflow / underflow flags
// Build option: FP_NORM_ROUND_EN selects round-to-nearest-even;
// without it the mantissa is truncated.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic        sign,
  input  logic [8:0]  exp,
  input  logic [26:0] sum,
  input  logic [1:0]  special,
  input  logic        denorm,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  logic [22:0] man_s;
  logic [30:0] field_s;
  logic        inc_s;

  // Field assembly, optional rounding and saturation.
  always_comb begin
    result    = 32'd0;
    overflow  = 1'b0;
    underflow = 1'b0;
    man_s     = sum[24:2];
    field_s   = 31'd0;
`ifdef FP_NORM_ROUND_EN
    // Nearest-even: round up on guard unless it is an exact tie with even lsb.
    inc_s = sum[1] & (sum[0] | sum[2]);
`else
    inc_s = 1'b0;
`endif
    if (special != SPC_NORMAL) begin
      case (special)
        SPC_INF:  result = {sign, EXP_INF, 23'd0};
        SPC_NAN:  result = {sign, EXP_INF, QNAN_MAN};
        SPC_RSVD: result = {sign, EXP_INF, QNAN_MAN};
        default:  result = {sign, EXP_INF, QNAN_MAN};
      endcase
    end else if (!denorm && (exp >= 9'd255)) begin
      // Exponent already at or past infinity (carry out of 254 or 255).
      result   = {sign, EXP_INF, 23'd0};
      overflow = 1'b1;
    end else begin
      // Increment spans exponent and mantissa so a mantissa carry bumps the
      // exponent and a denormal can promote to the smallest normal.
      if (denorm) begin
        field_s = {8'h00, man_s} + {30'd0, inc_s};
      end else begin
        field_s = {exp[7:0], man_s} + {30'd0, inc_s};
      end
      if (field_s[30:23] == EXP_INF) begin
        result   = {sign, EXP_INF, 23'd0};
        overflow = 1'b1;
      end else begin
        result    = {sign, field_s};
        // Only a nonzero sum that lands in the denormal/zero range underflows.
        underflow = denorm && (field_s[30:23] == 8'h00) && (|sum);
      end
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Sequential post-adder normalizer and binary32 packer.
// Accepts a raw signed-magnitude sum with its working exponent, folds a
// carry-out at capture, then left-normalizes one bit per cycle until the
// hidden bit is set, the exponent bottoms out or MAX_SHIFT steps are
// used, and finally packs the result (fp_round_pack).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (drops any in-flight operation)
//   bus  : fp_norm_pack_if.slave -- in_* operand channel, out_* result
//          channel, both valid/ready
// Parameter: MAX_SHIFT -- upper bound on left-normalization steps.
// Build option: FP_NORM_ROUND_EN enables round-to-nearest-even at pack.
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter int MAX_SHIFT = 24
) (
  input  logic          clk,
  input  logic          rst,
  fp_norm_pack_if.slave bus
);

  localparam int                CNT_W   = $clog2(MAX_SHIFT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);

  state_t            state_r;
  logic              sign_r;
  logic [8:0]        exp_r;
  logic [26:0]       sum_r;
  logic [1:0]        special_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              out_valid_r;
  logic [31:0]       out_result_r;
  logic              out_overflow_r;
  logic              out_underflow_r;

  logic [26:0]       cap_sum_s;
  logic [8:0]        cap_exp_s;
  logic              done_s;
  logic              denorm_s;
  logic [31:0]       pack_result_s;
  logic              pack_overflow_s;
  logic              pack_underflow_s;

  assign bus.in_ready      = (state_r == IDLE) && !rst;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_result    = out_result_r;
  assign bus.out_overflow  = out_overflow_r;
  assign bus.out_underflow = out_underflow_r;

  // Capture view: a carry-out is folded back with guard and sticky merged.
  always_comb begin
    cap_sum_s = bus.in_sum;
    cap_exp_s = {1'b0, bus.in_exp};
    if (bus.in_sum[26]) begin
      cap_sum_s = {1'b0, bus.in_sum[26:2], bus.in_sum[1] | bus.in_sum[0]};
      cap_exp_s = {1'b0, bus.in_exp} + 9'd1;
    end else begin
      cap_sum_s = bus.in_sum;
      cap_exp_s = {1'b0, bus.in_exp};
    end
  end

  // SHIFT-state termination test in priority order; zero packs via the
  // denormal path, which yields {s,00,0} with no underflow.
  always_comb begin
    done_s   = 1'b0;
    denorm_s = 1'b0;
    if (special_r != SPC_NORMAL) begin
      done_s   = 1'b1;
      denorm_s = 1'b0;
    end else if (sum_r == 27'd0) begin
      done_s   = 1'b1;
      denorm_s = 1'b1;
    end else if (sum_r[25]) begin
      done_s   = 1'b1;
      denorm_s = 1'b0;
    end else if ((exp_r <= 9'd1) || (cnt_r == CNT_MAX)) begin
      done_s   = 1'b1;
      denorm_s = 1'b1;
    end else begin
      done_s   = 1'b0;
      denorm_s = 1'b0;
    end
  end

  fp_round_pack u_pack (
    .sign      (sign_r),
    .exp       (exp_r),
    .sum       (sum_r),
    .special   (special_r),
    .denorm    (denorm_s),
    .result    (pack_result_s),
    .overflow  (pack_overflow_s),
    .underflow (pack_underflow_s)
  );

  // Control FSM with operand datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      sign_r          <= 1'b0;
      exp_r           <= 9'd0;
      sum_r           <= 27'd0;
      special_r       <= 2'b00;
      cnt_r           <= '0;
      out_valid_r     <= 1'b0;
      out_result_r    <= 32'd0;
      out_overflow_r  <= 1'b0;
      out_underflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            sign_r    <= bus.in_sign;
            exp_r     <= cap_exp_s;
            sum_r     <= cap_sum_s;
            special_r <= bus.in_special;
            cnt_r     <= '0;
            state_r   <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (done_s) begin
            out_result_r    <= pack_result_s;
            out_overflow_r  <= pack_overflow_s;
            out_underflow_r <= pack_underflow_s;
            out_valid_r     <= 1'b1;
            state_r         <= DONE;
          end else begin
            sum_r <= {sum_r[25:0], 1'b0};
            exp_r <= exp_r - 9'd1;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          // Result is held untouched until the consumer takes it.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_norm_pack.md
# fp_norm_pack

Sequential post-adder normalizer and packer for single-precision floating point. It sits directly downstream of the mantissa add/subtract stage and accepts the raw signed-magnitude sum with its working exponent. It normalizes the sum one bit per cycle, optionally rounds, and emits a packed IEEE-754 binary32 word. Both sides use valid/ready handshakes.

## Interface
Parameters:
- MAX_SHIFT, 24: upper bound on left-normalization steps per operation.

Ports:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  block can accept; equals (state==IDLE) && !rst.
- in_sign  in  1  result sign from the adder (sign of larger operand).
- in_exp  in  8  working exponent (larger operand's biased exponent).
- in_sum  in  27  [26] carry, [25] hidden, [24:2] mantissa, [1] guard, [0] sticky.
- in_special  in  2  00 normal, 01 infinity, 10 NaN, 11 reserved (treated as NaN).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts.
- out_result  out  32  packed {sign, exp[7:0], man[22:0]}.
- out_overflow  out  1  result saturated to infinity from finite input.
- out_underflow  out  1  result denormal or zero after nonzero sum.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: when in_valid && in_ready, capture all inputs. If in_sum[26]=1, right-shift once at capture: sum = {0, sum[26:2], sum[1]|sum[0]}, exp+1. Then go to SHIFT.
- SHIFT, evaluated in priority order each cycle:
  - special≠00: pack inf {s,FF,0} or NaN {s,FF,400000}, then DONE.
  - sum==0: pack {s,00,0}, then DONE. Underflow=0.
  - sum[25]=1: pack normal, then DONE.
  - exp<=1, or shift count==MAX_SHIFT: pack denormal with exp field 0 and man=sum[24:2], underflow=1, then DONE.
  - Otherwise: sum<<=1 (zero fill), exp-1, count+1.
- Overflow: exp==255 after the carry shift or after rounding gives {s,FF,0} with out_overflow=1.
- DONE: out_valid=1. When out_ready=1, return to IDLE with out_valid=0. No new capture occurs in the same cycle.
- Exponent arithmetic uses 9 bits internally. A capture exp of 255 with carry set counts as overflow.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_overflow 0, out_underflow 0, shift count 0. in_ready is 0 while rst=1.
- Latency from the accept edge to out_valid high is n+1 cycles, where n is the number of left shifts (0..MAX_SHIFT).
- Throughput is one operation per n+3 cycles minimum; there is no overlap.
- out_result and flags are stable while out_valid=1 && out_ready=0.
- If rst is asserted mid-operation, the in-flight operation is dropped with no output. The block is in IDLE on the next cycle.
- in_valid while busy is ignored; upstream must hold it.

## Configuration
- FP_NORM_ROUND_EN defined: round-to-nearest-even at pack.
  - Increment when guard && (sticky || man[0]).
  - The increment is applied to the 31-bit {exp_field, man}, so mantissa carry bumps the exponent and a denormal can promote to normal.
  - A result reaching FF sets overflow and forces man=0.
- FP_NORM_ROUND_EN undefined: truncate. Guard and sticky are ignored.

## Structure
- Shared package fp_pkg holds:
  - The state enum.
  - The constants EXP_INF=8'hFF, QNAN_MAN=23'h400000 and BIAS=127.
  - Special-code localparams.
- One combinational sub-module, fp_round_pack: takes {sign, exp, sum, special, denorm} and produces {result, overflow, underflow}. It contains the FP_NORM_ROUND_EN logic.

## Test plan
- 1.0+1.0: exp=127, sum=1<<26, special=00 -> 0x40000000 after 1 cycle, no flags.
- Cancellation: exp=130, sum=1<<24 -> 0x40800000 after 2 cycles.
- Exact cancel: sign=1, exp=140, sum=0 -> 0x80000000 after 1 cycle, no flags.
- Overflow and special inputs:
  - exp=254, sum=1<<26 -> 0x7F800000, out_overflow=1.
  - special=10 -> 0x7FC00000.
- Underflow: exp=3, sum=1<<22 -> 0x00400000 after 3 cycles, out_underflow=1.
- Rounding and backpressure:
  - exp=127, sum={01, all-ones mantissa, guard=1, sticky=0} -> 0x40000000 with FP_NORM_ROUND_EN, 0x3FFFFFFF without it.
  - Hold out_ready=0 for 5 cycles: result stable and in_ready=0 throughout.
  - Assert rst mid-SHIFT: no out_valid pulse, and in_ready=1 the cycle after reset is released.
